// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared types and constants for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DELIVER = 2'd1,
    HALT    = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Instruction-memory and decode-side signals of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        pc_src;
  logic        jump_type;
  logic [31:0] imm_ext;
  logic [31:0] alu_result;
  logic        flush;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        fault;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc_out, pc_plus4, fault,
    input  imem_ready, imem_rdata, pc_src, jump_type, imm_ext, alu_result,
           flush, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc_out, pc_plus4, fault,
    output imem_ready, imem_rdata, pc_src, jump_type, imm_ext, alu_result,
           flush, instr_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_next_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_gen
// Description : Combinational next-PC selection (sequential, JAL/branch, JALR).
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_gen
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  input  logic        pc_src,
  input  logic        jump_type,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] w_target;

  // JALR target drops bit 0 before the alignment check.
  assign w_target   = jump_type ? (alu_result & ~32'h0000_0001) : (pc + imm_ext);
  assign next_pc    = pc_src ? w_target : (pc + 32'd4);
  assign misaligned = pc_src && is_misaligned(w_target);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PC register, fetch FSM and valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic         r_valid;
  logic         r_fault;
  logic [31:0]  w_next_pc;
  logic         w_misaligned;

  next_pc_gen u_next_pc_gen (
    .pc         (r_pc),
    .imm_ext    (bus.imm_ext),
    .alu_result (bus.alu_result),
    .pc_src     (bus.pc_src),
    .jump_type  (bus.jump_type),
    .next_pc    (w_next_pc),
    .misaligned (w_misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          // A flush coinciding with imem_ready drops the data and re-requests.
          if (bus.flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
          end else if (bus.imem_ready) begin
            r_instr <= bus.imem_rdata;
            r_valid <= 1'b1;
            r_state <= DELIVER;
          end
        end
        DELIVER: begin
          if (bus.flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_state <= FETCH;
          end else if (bus.instr_ready) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            if (w_misaligned) begin
              r_fault <= 1'b1;
              r_state <= HALT;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= FETCH;
            end
          end
        end
        HALT: begin
          r_valid <= 1'b0;
          r_fault <= 1'b1;
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  // Gated by rst_n so the request drops the instant reset asserts.
  assign bus.imem_req    = rst_n && (r_state == FETCH);
  assign bus.imem_addr   = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_valid;
  assign bus.pc_out      = r_pc;
  assign bus.pc_plus4    = r_pc + 32'd4;
  assign bus.fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed scoreboard bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        sb_q[$];
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;
  logic [31:0] m_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[24:0], 7'h33};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Request at m_pc, stall for `delay` cycles, then return the word.
  task automatic fetch_ok(input int delay);
    exp_t e;
    for (int i = 0; i < delay; i++) begin
      bus.imem_ready = 1'b0;
      chk("stall_req", 32'(bus.imem_req), 32'd1);
      chk("stall_addr", bus.imem_addr, m_pc);
      chk("stall_valid", 32'(bus.instr_valid), 32'd0);
      cyc();
    end
    chk("req", 32'(bus.imem_req), 32'd1);
    chk("addr", bus.imem_addr, m_pc);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = mem_word(m_pc);
    sb_q.push_back(exp_t'{pc: m_pc, instr: mem_word(m_pc)});
    cyc();
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;
    chk("valid", 32'(bus.instr_valid), 32'd1);
    chk("req_in_deliver", 32'(bus.imem_req), 32'd0);
    if (sb_q.size() == 0) begin
      n_total++;
      n_fail++;
      $error("FAIL sb_empty: observed valid output, expected none");
    end else begin
      e = sb_q.pop_front();
      chk("instr", bus.instr, e.instr);
      chk("pc_out", bus.pc_out, e.pc);
      chk("pc_plus4", bus.pc_plus4, e.pc + 32'd4);
    end
  endtask

  // Hold the output for wait_n cycles with decoy controls, then accept.
  task automatic deliver(input int wait_n, input logic src, input logic jt,
                         input logic [31:0] imm, input logic [31:0] alu);
    logic [31:0] target;
    logic [31:0] nxt;
    for (int i = 0; i < wait_n; i++) begin
      bus.instr_ready = 1'b0;
      bus.pc_src      = 1'b1;
      bus.jump_type   = 1'b0;
      bus.imm_ext     = 32'h2;
      cyc();
      chk("hold_valid", 32'(bus.instr_valid), 32'd1);
      chk("hold_instr", bus.instr, mem_word(m_pc));
      chk("hold_pc", bus.pc_out, m_pc);
      chk("hold_req", 32'(bus.imem_req), 32'd0);
    end
    bus.instr_ready = 1'b1;
    bus.pc_src      = src;
    bus.jump_type   = jt;
    bus.imm_ext     = imm;
    bus.alu_result  = alu;
    target = jt ? {alu[31:1], 1'b0} : m_pc + imm;
    nxt    = src ? target : m_pc + 32'd4;
    cyc();
    bus.instr_ready = 1'b0;
    bus.pc_src      = 1'b0;
    if (nxt[1:0] != 2'b00) begin
      chk("fault_set", 32'(bus.fault), 32'd1);
      chk("fault_valid", 32'(bus.instr_valid), 32'd0);
      chk("fault_req", 32'(bus.imem_req), 32'd0);
      chk("fault_pc", bus.pc_out, m_pc);
    end else begin
      m_pc = nxt;
      chk("acc_valid", 32'(bus.instr_valid), 32'd0);
      chk("acc_instr", bus.instr, NOP);
      chk("acc_req", 32'(bus.imem_req), 32'd1);
      chk("acc_addr", bus.imem_addr, m_pc);
      chk("acc_fault", 32'(bus.fault), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    bus.imem_ready  = 1'b0;
    bus.imem_rdata  = '0;
    bus.pc_src      = 1'b0;
    bus.jump_type   = 1'b0;
    bus.imm_ext     = '0;
    bus.alu_result  = '0;
    bus.flush       = 1'b0;
    bus.instr_ready = 1'b0;
    #12;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_instr", bus.instr, NOP);
    chk("rst_pc", bus.pc_out, 32'h0);
    chk("rst_pc4", bus.pc_plus4, 32'h4);
    cyc();
    rst_n = 1'b1;
    m_pc  = 32'h0;
    #1;

    // Zero-wait streaming, then a 3-cycle stall at 0x8.
    fetch_ok(0); deliver(0, 1'b0, 1'b0, 32'h0, 32'h0);
    fetch_ok(0); deliver(0, 1'b0, 1'b0, 32'h0, 32'h0);
    fetch_ok(3); deliver(0, 1'b0, 1'b0, 32'h0, 32'h0);
    fetch_ok(0); deliver(0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Branch back from 0x10, then JALR to 0x41 -> 0x40.
    fetch_ok(0); deliver(0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0);
    chk("branch_addr", bus.imem_addr, 32'h8);
    fetch_ok(0); deliver(0, 1'b1, 1'b1, 32'h0, 32'h41);
    chk("jalr_addr", bus.imem_addr, 32'h40);

    // Downstream backpressure for 5 cycles.
    fetch_ok(0); deliver(5, 1'b0, 1'b0, 32'h0, 32'h0);

    // Flush in DELIVER at 0x30, then flush racing imem_ready in FETCH.
    fetch_ok(0); deliver(0, 1'b1, 1'b1, 32'h0, 32'h30);
    fetch_ok(0);
    bus.flush = 1'b1;
    cyc();
    chk("flush_valid", 32'(bus.instr_valid), 32'd0);
    chk("flush_instr", bus.instr, NOP);
    chk("flush_req", 32'(bus.imem_req), 32'd1);
    chk("flush_addr", bus.imem_addr, 32'h30);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    cyc();
    bus.flush      = 1'b0;
    bus.imem_ready = 1'b0;
    chk("flushf_valid", 32'(bus.instr_valid), 32'd0);
    chk("flushf_addr", bus.imem_addr, 32'h30);
    chk("flushf_req", 32'(bus.imem_req), 32'd1);

    // 0x30 - 0x10 = 0x20, then misaligned branch to 0x26.
    fetch_ok(0); deliver(0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
    fetch_ok(0); deliver(0, 1'b1, 1'b0, 32'h6, 32'h0);
    bus.flush      = 1'b1;
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("halt_fault", 32'(bus.fault), 32'd1);
      chk("halt_valid", 32'(bus.instr_valid), 32'd0);
      chk("halt_req", 32'(bus.imem_req), 32'd0);
    end
    bus.flush      = 1'b0;
    bus.imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("halt_rst_fault", 32'(bus.fault), 32'd0);
    chk("halt_rst_addr", bus.imem_addr, 32'h0);
    cyc();
    rst_n = 1'b1;
    m_pc  = 32'h0;
    #1;
    chk("post_rst_req", 32'(bus.imem_req), 32'd1);

    // Reset abandoning a pending request at 0x4.
    fetch_ok(0); deliver(0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    chk("pend_req", 32'(bus.imem_req), 32'd1);
    chk("pend_addr", bus.imem_addr, 32'h4);
    rst_n = 1'b0;
    #1;
    chk("async_req", 32'(bus.imem_req), 32'd0);
    chk("async_pc", bus.pc_out, 32'h0);
    cyc();
    rst_n = 1'b1;
    m_pc  = 32'h0;
    #1;

    // Wrap from 0xFFFF_FFFC back to 0.
    fetch_ok(0); deliver(0, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFD);
    fetch_ok(0);
    chk("wrap_pc4", bus.pc_plus4, 32'h0);
    deliver(0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wrap_addr", bus.imem_addr, 32'h0);
    fetch_ok(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
